branch_target_buffer_2bc: RTL and testbench
===========================================

// Module: branch_target_buffer_2bc
// PURPOSE
//  Direct-mapped branch target buffer with per-entry 2-bit saturating direction counters.
//  Successor to the fixed 8-row BTB: entry count, PC width and index position are parameters.
//  Adds valid bits, counter-based taken/not-taken prediction, not-taken training and a global flush.
//  Sits beside the fetch PC register; trained from the branch-resolve stage.
// PARAMETERS
//  PC_W     64  PC / target width in bits
//  ENTRIES  8   number of rows; power of 2, >= 2
//  IDX_LSB  2   lowest PC bit used as index (byte-addressed 4-byte instructions)
// PORTS
//  clk            in   1     rising-edge clock
//  rst            in   1     synchronous, active-high reset
//  en             in   1     lookup enable; 0 = fetch stall, prediction outputs hold
//  flush          in   1     invalidate all entries
//  current_pc     in   PC_W  fetch PC to look up
//  upd_valid      in   1     resolved control-transfer info valid this cycle
//  upd_pc         in   PC_W  PC of the resolved branch/jump
//  upd_target     in   PC_W  resolved target address
//  upd_taken      in   1     conditional branch resolved taken
//  upd_jump       in   1     unconditional jump (treated as taken, strongly)
//  pred_hit       out  1     current_pc matched a valid entry
//  pred_taken     out  1     hit and counter >= 2
//  predicted_pc   out  PC_W  target if pred_taken, else 0
// BEHAVIOUR
//  Storage per row: valid, tag (full PC_W PC), target (PC_W), ctr (2 bits).
//  Index = pc[IDX_LSB+log2(ENTRIES)-1 : IDX_LSB], same function for lookup and update.
//  Reset (rst=1 at edge): all valid=0, ctr=0, tag/target=0; pred_hit=0, pred_taken=0, predicted_pc=0.
//  Lookup: latency 1 cycle. When en=1, at the edge the outputs register:
//    hit = valid[idx] && tag[idx]==current_pc; pred_taken = hit && ctr[idx][1];
//    predicted_pc = pred_taken ? target[idx] : 0.  When en=0, outputs hold.
//  Lookup reads array state from before the same edge's update (no write-to-read bypass).
//  Update (upd_valid=1, independent of en); eff_taken = upd_taken | upd_jump:
//    row hit (valid && tag==upd_pc): target<=upd_target if eff_taken;
//      upd_jump -> ctr<=3; else taken -> ctr<=min(ctr+1,3); not taken -> ctr<=max(ctr-1,0).
//    row miss, eff_taken: allocate/replace: valid<=1, tag<=upd_pc, target<=upd_target,
//      ctr<=3 if upd_jump else 2.
//    row miss, not taken: no change.
//    upd_taken and upd_jump both 1: treated as jump.
//  Hit with ctr decremented to 0/1 keeps valid=1 (entry retained, predicts not-taken).
//  flush=1: all valid<=0 at edge (ctr/tag/target don't-care); any same-cycle update is dropped;
//    outputs register a miss if en=1 that cycle (hold otherwise).
//  rst has priority over flush, update and lookup; rst mid-stream clears everything in one cycle.
//  Aliasing: PCs differing only above the index bits replace each other (direct mapped).
// TESTING
//  1 After rst, en=1, current_pc=0x100 -> next cycle pred_hit=0, pred_taken=0, predicted_pc=0.
//  2 upd pc=0x104 target=0x200 taken; then lookup 0x104 -> hit=1, taken=1, predicted_pc=0x200 (ctr=2).
//  3 Same entry: two not-taken updates -> ctr 2->1->0; lookup 0x104 -> hit=1, taken=0, predicted_pc=0;
//    four taken updates -> ctr saturates at 3, lookup predicts 0x200.
//  4 ENTRIES=8: entry at 0x104, then jump update pc=0x124 target=0x300 (same idx 1) -> lookup 0x104 miss,
//    lookup 0x124 hit, predicted_pc=0x300; not-taken update to unmapped pc 0x108 -> row 2 stays invalid.
//  5 Same-cycle update and lookup of 0x10C on empty row -> that cycle's output miss; next lookup hits.
//  6 en=0 with changing current_pc -> outputs frozen; flush=1 with upd_valid=1 -> all lookups miss,
//    update not installed; rst asserted mid-training -> all outputs 0 next cycle.

Source files
------------

// File: rtl/branch_target_buffer_2bc.sv
// Direct-mapped branch target buffer with per-row 2-bit saturating direction counters.
// Registered one-cycle lookup from the fetch PC; training from the branch-resolve stage.
module branch_target_buffer_2bc #(
    parameter int PC_W    = 64,
    parameter int ENTRIES = 8,
    parameter int IDX_LSB = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            flush,
    input  logic [PC_W-1:0] current_pc,
    input  logic            upd_valid,
    input  logic [PC_W-1:0] upd_pc,
    input  logic [PC_W-1:0] upd_target,
    input  logic            upd_taken,
    input  logic            upd_jump,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [PC_W-1:0] predicted_pc
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic            valid_r  [ENTRIES];
    logic [PC_W-1:0] tag_r    [ENTRIES];
    logic [PC_W-1:0] target_r [ENTRIES];
    logic [1:0]      ctr_r    [ENTRIES];

    logic [IDX_W-1:0] lk_idx_s;
    logic [IDX_W-1:0] up_idx_s;
    logic             lk_hit_s;
    logic             lk_taken_s;
    logic [PC_W-1:0]  lk_pc_s;
    logic             up_hit_s;
    logic             eff_taken_s;
    logic             wr_en_s;
    logic [PC_W-1:0]  wr_tag_s;
    logic [PC_W-1:0]  wr_target_s;
    logic [1:0]       wr_ctr_s;

    assign lk_idx_s = current_pc[IDX_LSB +: IDX_W];
    assign up_idx_s = upd_pc[IDX_LSB +: IDX_W];

    // Lookup against the array contents as they stand before this edge's write.
    always_comb begin
        lk_hit_s   = valid_r[lk_idx_s] && (tag_r[lk_idx_s] == current_pc);
        lk_taken_s = lk_hit_s && ctr_r[lk_idx_s][1];
        if (lk_taken_s) begin
            lk_pc_s = target_r[lk_idx_s];
        end else begin
            lk_pc_s = {PC_W{1'b0}};
        end
    end

    // Training decision for the single row addressed by the resolved branch.
    always_comb begin
        up_hit_s    = valid_r[up_idx_s] && (tag_r[up_idx_s] == upd_pc);
        eff_taken_s = upd_taken | upd_jump;
        wr_en_s     = 1'b0;
        wr_tag_s    = tag_r[up_idx_s];
        wr_target_s = target_r[up_idx_s];
        wr_ctr_s    = ctr_r[up_idx_s];
        if (upd_valid && !flush) begin
            if (up_hit_s) begin
                wr_en_s = 1'b1;
                if (eff_taken_s) begin
                    wr_target_s = upd_target;
                end else begin
                    wr_target_s = target_r[up_idx_s];
                end
                if (upd_jump) begin
                    wr_ctr_s = 2'd3;
                end else if (upd_taken) begin
                    wr_ctr_s = (ctr_r[up_idx_s] == 2'd3) ? 2'd3 : ctr_r[up_idx_s] + 2'd1;
                end else begin
                    wr_ctr_s = (ctr_r[up_idx_s] == 2'd0) ? 2'd0 : ctr_r[up_idx_s] - 2'd1;
                end
            end else if (eff_taken_s) begin
                // Miss on a taken transfer replaces whatever aliased into the row.
                wr_en_s     = 1'b1;
                wr_tag_s    = upd_pc;
                wr_target_s = upd_target;
                wr_ctr_s    = upd_jump ? 2'd3 : 2'd2;
            end else begin
                wr_en_s = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Array storage: reset clears everything, flush drops validity, else one-row write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= {PC_W{1'b0}};
                target_r[i] <= {PC_W{1'b0}};
                ctr_r[i]    <= 2'd0;
            end
        end else if (flush) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i] <= 1'b0;
            end
        end else if (wr_en_s) begin
            valid_r[up_idx_s]  <= 1'b1;
            tag_r[up_idx_s]    <= wr_tag_s;
            target_r[up_idx_s] <= wr_target_s;
            ctr_r[up_idx_s]    <= wr_ctr_s;
        end
    end

    // Registered prediction outputs; hold while fetch is stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            pred_hit     <= 1'b0;
            pred_taken   <= 1'b0;
            predicted_pc <= {PC_W{1'b0}};
        end else if (en) begin
            if (flush) begin
                pred_hit     <= 1'b0;
                pred_taken   <= 1'b0;
                predicted_pc <= {PC_W{1'b0}};
            end else begin
                pred_hit     <= lk_hit_s;
                pred_taken   <= lk_taken_s;
                predicted_pc <= lk_pc_s;
            end
        end
    end
endmodule

// File: tb/tb_branch_target_buffer_2bc.sv
// Self-checking bench for branch_target_buffer_2bc: directed vector table plus
// randomized traffic checked against a table-level behavioural model.
module tb_branch_target_buffer_2bc;
    logic        clk = 1'b0;
    logic        rst, en, flush, upd_valid, upd_taken, upd_jump;
    logic [63:0] current_pc, upd_pc, upd_target;
    logic        pred_hit, pred_taken;
    logic [63:0] predicted_pc;

    int n_checks = 0;
    int n_fail   = 0;

    branch_target_buffer_2bc #(.PC_W(64), .ENTRIES(8), .IDX_LSB(2)) dut (
        .clk(clk), .rst(rst), .en(en), .flush(flush), .current_pc(current_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_target(upd_target),
        .upd_taken(upd_taken), .upd_jump(upd_jump), .pred_hit(pred_hit),
        .pred_taken(pred_taken), .predicted_pc(predicted_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          rst, en, flush, uv, ut, uj;
        logic [63:0] cpc, upc, utgt;
        bit          e_hit, e_tk;
        logic [63:0] e_pc;
    } vec_t;

    vec_t vecs[$];

    // Behavioural model: a table of rows with integer confidence counters.
    bit          m_valid[8];
    logic [63:0] m_tag[8], m_tgt[8];
    int          m_ctr[8];
    bit          x_hit, x_tk;
    logic [63:0] x_pc;

    function automatic int row_of(logic [63:0] pc);
        return int'((pc >> 2) % 64'd8);
    endfunction

    task automatic model_edge();
        int r;
        if (rst) begin
            for (int i = 0; i < 8; i++) begin
                m_valid[i] = 1'b0; m_ctr[i] = 0; m_tag[i] = 64'd0; m_tgt[i] = 64'd0;
            end
            x_hit = 1'b0; x_tk = 1'b0; x_pc = 64'd0;
        end else begin
            if (en) begin
                r     = row_of(current_pc);
                x_hit = !flush && m_valid[r] && m_tag[r] == current_pc;
                x_tk  = x_hit && m_ctr[r] >= 2;
                x_pc  = x_tk ? m_tgt[r] : 64'd0;
            end
            if (flush) begin
                for (int i = 0; i < 8; i++) m_valid[i] = 1'b0;
            end else if (upd_valid) begin
                r = row_of(upd_pc);
                if (m_valid[r] && m_tag[r] == upd_pc) begin
                    if (upd_taken || upd_jump) m_tgt[r] = upd_target;
                    if (upd_jump)       m_ctr[r] = 3;
                    else if (upd_taken) m_ctr[r] = (m_ctr[r] + 1 > 3) ? 3 : m_ctr[r] + 1;
                    else                m_ctr[r] = (m_ctr[r] - 1 < 0) ? 0 : m_ctr[r] - 1;
                end else if (upd_taken || upd_jump) begin
                    m_valid[r] = 1'b1; m_tag[r] = upd_pc; m_tgt[r] = upd_target;
                    m_ctr[r] = upd_jump ? 3 : 2;
                end
            end
        end
    endtask

    task automatic check(string name, int idx, bit e_hit, bit e_tk, logic [63:0] e_pc);
        n_checks++;
        if (pred_hit !== e_hit || pred_taken !== e_tk || predicted_pc !== e_pc) begin
            n_fail++;
            $display("FAIL %s[%0d]: got hit=%0b taken=%0b pc=%h, expected hit=%0b taken=%0b pc=%h",
                     name, idx, pred_hit, pred_taken, predicted_pc, e_hit, e_tk, e_pc);
        end
    endtask

    task automatic drive(bit r, bit e, bit f, logic [63:0] cpc, bit uv,
                         logic [63:0] upc, logic [63:0] utgt, bit ut, bit uj);
        rst = r; en = e; flush = f; current_pc = cpc; upd_valid = uv;
        upd_pc = upc; upd_target = utgt; upd_taken = ut; upd_jump = uj;
    endtask

    function automatic vec_t mk(bit r, bit e, bit f, logic [63:0] cpc, bit uv,
                                logic [63:0] upc, logic [63:0] utgt, bit ut, bit uj,
                                bit eh, bit et, logic [63:0] ep);
        vec_t v;
        v.rst = r; v.en = e; v.flush = f; v.cpc = cpc; v.uv = uv; v.upc = upc;
        v.utgt = utgt; v.ut = ut; v.uj = uj; v.e_hit = eh; v.e_tk = et; v.e_pc = ep;
        return v;
    endfunction

    initial begin
        //            rst en fl cpc         uv upc        utgt       ut uj   hit tk pc
        vecs.push_back(mk(1, 0, 0, 64'h0,    0, 64'h0,    64'h0,     0, 0,   0, 0, 64'h0));
        vecs.push_back(mk(0, 1, 0, 64'h100,  0, 64'h0,    64'h0,     0, 0,   0, 0, 64'h0));
        vecs.push_back(mk(0, 1, 0, 64'h104,  1, 64'h104,  64'h200,   1, 0,   0, 0, 64'h0));
        vecs.push_back(mk(0, 1, 0, 64'h104,  0, 64'h0,    64'h0,     0, 0,   1, 1, 64'h200));
        vecs.push_back(mk(0, 1, 0, 64'h104,  1, 64'h104,  64'h0,     0, 0,   1, 1, 64'h200));
        vecs.push_back(mk(0, 1, 0, 64'h104,  1, 64'h104,  64'h0,     0, 0,   1, 0, 64'h0));
        vecs.push_back(mk(0, 1, 0, 64'h104,  0, 64'h0,    64'h0,     0, 0,   1, 0, 64'h0));
        vecs.push_back(mk(0, 1, 0, 64'h104,  1, 64'h104,  64'h200,   1, 0,   1, 0, 64'h0));
        vecs.push_back(mk(0, 1, 0, 64'h104,  1, 64'h104,  64'h200,   1, 0,   1, 0, 64'h0));
        vecs.push_back(mk(0, 1, 0, 64'h104,  1, 64'h104,  64'h200,   1, 0,   1, 1, 64'h200));
        vecs.push_back(mk(0, 1, 0, 64'h104,  1, 64'h104,  64'h200,   1, 0,   1, 1, 64'h200));
        vecs.push_back(mk(0, 1, 0, 64'h104,  0, 64'h0,    64'h0,     0, 0,   1, 1, 64'h200));
        // aliasing jump into row 1, and a not-taken miss that must not allocate
        vecs.push_back(mk(0, 1, 0, 64'h104,  1, 64'h124,  64'h300,   0, 1,   1, 1, 64'h200));
        vecs.push_back(mk(0, 1, 0, 64'h104,  0, 64'h0,    64'h0,     0, 0,   0, 0, 64'h0));
        vecs.push_back(mk(0, 1, 0, 64'h124,  0, 64'h0,    64'h0,     0, 0,   1, 1, 64'h300));
        vecs.push_back(mk(0, 1, 0, 64'h108,  1, 64'h108,  64'h0,     0, 0,   0, 0, 64'h0));
        vecs.push_back(mk(0, 1, 0, 64'h108,  0, 64'h0,    64'h0,     0, 0,   0, 0, 64'h0));
        // same-cycle update and lookup: no bypass
        vecs.push_back(mk(0, 1, 0, 64'h10C,  1, 64'h10C,  64'h400,   1, 0,   0, 0, 64'h0));
        vecs.push_back(mk(0, 1, 0, 64'h10C,  0, 64'h0,    64'h0,     0, 0,   1, 1, 64'h400));
        // stall holds outputs
        vecs.push_back(mk(0, 0, 0, 64'h104,  0, 64'h0,    64'h0,     0, 0,   1, 1, 64'h400));
        vecs.push_back(mk(0, 0, 0, 64'h124,  0, 64'h0,    64'h0,     0, 0,   1, 1, 64'h400));
        // flush drops the same-cycle update
        vecs.push_back(mk(0, 1, 1, 64'h124,  1, 64'h110,  64'h500,   1, 0,   0, 0, 64'h0));
        vecs.push_back(mk(0, 1, 0, 64'h110,  0, 64'h0,    64'h0,     0, 0,   0, 0, 64'h0));
        vecs.push_back(mk(0, 1, 0, 64'h124,  0, 64'h0,    64'h0,     0, 0,   0, 0, 64'h0));
        vecs.push_back(mk(0, 1, 0, 64'h10C,  0, 64'h0,    64'h0,     0, 0,   0, 0, 64'h0));
        // reset mid-training clears everything
        vecs.push_back(mk(0, 1, 0, 64'h114,  1, 64'h114,  64'h600,   1, 1,   0, 0, 64'h0));
        vecs.push_back(mk(0, 1, 0, 64'h114,  0, 64'h0,    64'h0,     0, 0,   1, 1, 64'h600));
        vecs.push_back(mk(1, 1, 0, 64'h114,  1, 64'h114,  64'h700,   1, 0,   0, 0, 64'h0));
        vecs.push_back(mk(0, 1, 0, 64'h114,  0, 64'h0,    64'h0,     0, 0,   0, 0, 64'h0));

        drive(1, 0, 0, 64'h0, 0, 64'h0, 64'h0, 0, 0);
        @(negedge clk);
        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].en, vecs[i].flush, vecs[i].cpc, vecs[i].uv,
                  vecs[i].upc, vecs[i].utgt, vecs[i].ut, vecs[i].uj);
            @(posedge clk);
            model_edge();
            #1;
            check("vector", i, vecs[i].e_hit, vecs[i].e_tk, vecs[i].e_pc);
            @(negedge clk);
        end

        // Randomized traffic over a small PC pool so rows alias and hit often.
        for (int c = 0; c < 3000; c++) begin
            drive($urandom_range(0, 299) == 0, $urandom_range(0, 7) != 0,
                  $urandom_range(0, 59) == 0,
                  64'h1000 + 64'($urandom_range(0, 31)) * 64'd4,
                  $urandom_range(0, 1) == 1,
                  64'h1000 + 64'($urandom_range(0, 31)) * 64'd4,
                  {32'($urandom), 32'($urandom)},
                  $urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0);
            @(posedge clk);
            model_edge();
            #1;
            check("random", c, x_hit, x_tk, x_pc);
            @(negedge clk);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
